fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch.sv | 177 +++++++++++++++++
 tb/tb_fetch.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage.
//   if_id_t : fetch -> decode pipeline record {valid, pc, instr}.
package fetch_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage.
//
// Owns the PC and issues in-order word requests to instruction memory.
// Returned words go into a small circular buffer and are presented to
// decode through if_id_o. Redirects from execute flush the buffer, retarget
// the PC and mark every still-outstanding request as stale, so its response
// is thrown away when it eventually returns.
//
// Optional build macro:
//   FETCH_PERF_EN : adds perf_fetched_o (pop count) and perf_stall_o
//                   (cycles with valid output held by stall).
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   stall_i             decode cannot accept; head entry is held
//   redirect_valid_i    redirect from execute
//   redirect_pc_i       redirect target (bits [1:0] ignored)
//   imem_req_valid_o    request valid
//   imem_req_ready_i    memory accepts the request
//   imem_req_addr_o     word-aligned request address
//   imem_rsp_valid_i    response beat (always accepted, in request order)
//   imem_rsp_data_i     instruction word
//   perf_fetched_o      (FETCH_PERF_EN only) number of pops
//   perf_stall_o        (FETCH_PERF_EN only) stalled-with-valid cycles
//   if_id_o             {valid, pc, instr} to decode
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          BUF_DEPTH    = 4,
  parameter int          MAX_INFLIGHT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o,
`endif
  output if_id_t      if_id_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // State
  logic [31:0]      pc_q;
  logic [31:0]      rsp_pc_q;
  logic [IF_W-1:0]  inflight_q;
  logic [IF_W-1:0]  drop_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  entry_t           buf_mem [BUF_DEPTH];

  // Combinational control
  logic        req_valid;
  logic        req_fire;
  logic        pop;
  logic        push;
  logic [31:0] target;

  // Word-align the redirect target by masking rather than slicing.
  assign target = redirect_pc_i & ~32'h3;

  // Issue only while both the in-flight budget and the buffer space that
  // those in-flight requests may later claim allow it. Neither sum can grow
  // without a fire, so a pending request stays stable until accepted.
  always_comb begin
    req_valid = 1'b0;
    if (!rst_i && !redirect_valid_i &&
        (32'(inflight_q) < 32'(MAX_INFLIGHT)) &&
        ((32'(inflight_q) + 32'(count_q)) < 32'(BUF_DEPTH)))
      req_valid = 1'b1;
  end

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = req_valid && imem_req_ready_i;

  assign pop  = (count_q != '0) && !stall_i;
  // A beat is kept only when no stale requests remain ahead of it and no
  // redirect is discarding this cycle's traffic.
  assign push = imem_rsp_valid_i && (drop_q == '0) && !redirect_valid_i;

  // Head of the buffer; zero when empty so decode sees a clean bubble.
  always_comb begin
    if_id_o = '0;
    if (count_q != '0) begin
      if_id_o.valid = 1'b1;
      if_id_o.pc    = buf_mem[rd_ptr].pc;
      if_id_o.instr = buf_mem[rd_ptr].instr;
    end
  end

  // Buffer storage: no reset needed, validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push)
      buf_mem[wr_ptr] <= '{pc: rsp_pc_q, instr: imem_rsp_data_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      inflight_q <= inflight_q + IF_W'(req_fire) - IF_W'(imem_rsp_valid_i);
      if (redirect_valid_i) begin
        pc_q     <= target;
        rsp_pc_q <= target;
        count_q  <= '0;
        rd_ptr   <= wr_ptr;
        // Everything still outstanding after this cycle is stale.
        drop_q   <= inflight_q - IF_W'(imem_rsp_valid_i);
      end else begin
        if (req_fire)
          pc_q <= pc_q + 32'd4;
        if (imem_rsp_valid_i && (drop_q != '0))
          drop_q <= drop_q - 1'b1;
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          rsp_pc_q <= rsp_pc_q + 32'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop)
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if ((count_q != '0) && stall_i)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

  // The issue rule reserves a buffer slot for every in-flight request, so
  // a push into a full buffer means the bookkeeping is broken.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (32'(count_q) == 32'(BUF_DEPTH))));

  a_inflight_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    32'(inflight_q) <= 32'(MAX_INFLIGHT));

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios with literal
// expectations, then a randomized run checked against a queue-level model.
module tb_fetch;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXF  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  if_id_t      if_id;

  fetch #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH), .MAX_INFLIGHT(MAXF)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .redirect_valid_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready),
    .imem_req_addr_o(req_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .if_id_o(if_id)
  );

  always #5 clk = ~clk;

  // Model: the fetch stage seen as a stream of outstanding requests (each
  // possibly stale) feeding an ordered buffer of {pc, instr}.
  typedef struct { logic [31:0] addr; bit stale; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  infl_t       m_infl[$];
  ent_t        m_buf[$];
  logic [31:0] m_pc;
  logic [31:0] mem_q[$];   // addresses the memory still owes a response for
  logic [31:0] key = '0;   // data = addr ^ key

  int checks = 0;
  int errors = 0;

  bit          e_fire, a_fire;
  logic [31:0] a_addr;

  task automatic check(string nm, logic [64:0] act, logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_req_valid();
    return !rst && !redirect && (m_infl.size() < MAXF) &&
           (m_infl.size() + m_buf.size() < DEPTH);
  endfunction

  // Drive one cycle's inputs on the falling edge and compare every output.
  task automatic drive(bit st, bit rd, logic [31:0] rpc, bit rdy, bit rsp_en);
    @(negedge clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    req_ready   = rdy;
    rsp_valid   = rsp_en && (mem_q.size() > 0);
    rsp_data    = rsp_valid ? (mem_q[0] ^ key) : $urandom;
    #1;
    e_fire = exp_req_valid() && rdy;
    a_fire = req_valid && rdy;
    a_addr = req_addr;
    check("req_valid", 65'(req_valid), 65'(exp_req_valid()));
    if (exp_req_valid()) check("req_addr", 65'(req_addr), 65'(m_pc));
    check("if_id.valid", 65'(if_id.valid), 65'(m_buf.size() != 0));
    if (m_buf.size() != 0) begin
      check("if_id.pc", 65'(if_id.pc), 65'(m_buf[0].pc));
      check("if_id.instr", 65'(if_id.instr), 65'(m_buf[0].instr));
    end
  endtask

  // Advance memory and model across the rising edge.
  task automatic adv();
    infl_t e;
    @(posedge clk);
    if (rsp_valid) void'(mem_q.pop_front());
    if (a_fire) mem_q.push_back(a_addr);
    if (redirect) begin
      m_buf.delete();
      if (rsp_valid && m_infl.size() > 0) void'(m_infl.pop_front());
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_pc = redirect_pc & ~32'h3;
    end else begin
      if (m_buf.size() != 0 && !stall) void'(m_buf.pop_front());
      if (rsp_valid && m_infl.size() > 0) begin
        e = m_infl.pop_front();
        if (!e.stale) m_buf.push_back('{pc: e.addr, instr: rsp_data});
      end
      if (e_fire) begin
        m_infl.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    if (m_buf.size() > DEPTH) begin
      errors++;
      checks++;
      $display("FAIL model_overflow: got %0d expected <= %0d", m_buf.size(), DEPTH);
    end
  endtask

  task automatic clear_model();
    m_infl.delete();
    m_buf.delete();
    mem_q.delete();
    m_pc = 32'h0;
  endtask

  task automatic quiet_inputs();
    stall = 0; redirect = 0; redirect_pc = '0;
    req_ready = 0; rsp_valid = 0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    quiet_inputs();
    #1;
    check("reset.req_valid", 65'(req_valid), 65'(0));
    check("reset.if_id", 65'(if_id), 65'(0));
    clear_model();
    release_reset();
  endtask

  // Assert reset in the middle of a cycle and check the outputs fall at once.
  task automatic mid_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async.req_valid", 65'(req_valid), 65'(0));
    check("async.if_id.valid", 65'(if_id.valid), 65'(0));
    quiet_inputs();
    clear_model();
    release_reset();
  endtask

  initial begin
    // 1: streaming from reset, memory returns address as data.
    key = '0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 1, 1);
      if (c < 3) check("start.addr", 65'(req_addr), 65'(32'h4 * c));
      if (c == 2) begin
        check("start.first_valid", 65'(if_id.valid), 65'(1));
        check("start.first_pc", 65'(if_id.pc), 65'(32'h0));
        check("start.first_instr", 65'(if_id.instr), 65'(32'h0));
      end
      if (c == 3) check("start.second_pc", 65'(if_id.pc), 65'(32'h4));
      adv();
    end

    // 2: stall for 10 cycles, buffer fills, then drains in order.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, 0, 1, 1);
      if (c >= 5) check("stall.req_dropped", 65'(req_valid), 65'(0));
      adv();
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 1, 1);
      check("stall.drain_pc", 65'(if_id.pc), 65'(32'h4 * c));
      adv();
    end

    // 3: redirect to 0x103 with two requests outstanding.
    do_reset();
    for (int c = 0; c < 2; c++) begin drive(0, 0, 0, 1, 0); adv(); end
    drive(0, 1, 32'h103, 1, 0);
    check("redir.req_suppressed", 65'(req_valid), 65'(0));
    adv();
    for (int c = 3; c < 8; c++) begin
      drive(0, 0, 0, 1, 1);
      if (c == 3) check("redir.first_addr", 65'(req_addr), 65'(32'h100));
      if (c < 6)  check("redir.no_stale", 65'(if_id.valid), 65'(0));
      if (c == 6) check("redir.pc0", 65'(if_id.pc), 65'(32'h100));
      if (c == 7) check("redir.pc1", 65'(if_id.pc), 65'(32'h104));
      adv();
    end

    // 4: redirect coinciding with a response and a pop.
    for (int c = 0; c < 3; c++) begin drive(0, 0, 0, 1, 1); adv(); end
    drive(0, 1, 32'h200, 1, 1);
    check("coinc.rsp_present", 65'(rsp_valid), 65'(1));
    check("coinc.popping", 65'(if_id.valid), 65'(1));
    check("coinc.req_suppressed", 65'(req_valid), 65'(0));
    adv();
    drive(0, 0, 0, 1, 1);
    check("coinc.empty_after", 65'(if_id.valid), 65'(0));
    check("coinc.target_addr", 65'(req_addr), 65'(32'h200));
    adv();
    for (int c = 0; c < 4; c++) begin drive(0, 0, 0, 1, 1); adv(); end

    // 5: memory not ready for 5 cycles; address must hold.
    do_reset();
    for (int c = 0; c < 2; c++) begin drive(0, 0, 0, 1, 1); adv(); end
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 0, 0, 1);
      check("notready.valid", 65'(req_valid), 65'(1));
      check("notready.addr", 65'(req_addr), 65'(32'h8));
      adv();
    end
    for (int c = 0; c < 6; c++) begin drive(0, 0, 0, 1, 1); adv(); end

    // 6: asynchronous reset mid-stream with work outstanding.
    do_reset();
    for (int c = 0; c < 5; c++) begin drive(1, 0, 0, 1, (c > 1)); adv(); end
    mid_reset();
    drive(0, 0, 0, 1, 1);
    check("restart.addr", 65'(req_addr), 65'(32'h0));
    adv();

    // 7: randomized traffic.
    key = 32'h5A5A_0000;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) begin
        mid_reset();
      end else begin
        drive(($urandom_range(0, 9) < 3),
              ($urandom_range(0, 19) == 0),
              $urandom,
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) < 7));
        adv();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
